// File: rtl/ddr2_capture_fifo_pkg.sv
// ddr2_capture_fifo shared constants and Gray-code helpers.
// Imported by the capture buffer top level.
package ddr2_capture_fifo_pkg;

  localparam int BL4      = 4;
  localparam int BL8      = 8;
  localparam int DQ_W_DEF = 16;

  // Helpers operate on a fixed width; callers cast in and out.
  localparam int GW = 16;

  function automatic logic [GW-1:0] bin2gray(
    input logic [GW-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GW-1:0] gray2bin(
    input logic [GW-1:0] g
  );
    logic [GW-1:0] b;
    b[GW-1] = g[GW-1];
    for (int i = GW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ddr2_gray_sync.sv
// Two-flop synchroniser with asynchronous active-high reset.
// Carries Gray pointers and single-bit flags across domains.
module ddr2_gray_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ddr2_capture_fifo.sv
// DDR2 read-data capture buffer: DQS-edge capture into a pair FIFO.
// Define DDR2_CAPTURE_DLY_CHAIN_EN to insert the CLKBUF2 DQS delay chain.
module ddr2_capture_fifo
  import ddr2_capture_fifo_pkg::*;
#(
  parameter int DQ_W       = DQ_W_DEF,
  parameter int BL         = BL4,
  parameter int DEPTH      = 16,
  parameter int DLY_STAGES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     listen,
  input  logic                     strobe,
  input  logic [DQ_W-1:0]          din,
  input  logic                     rd_en,
  output logic [DQ_W-1:0]          dout,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     burst_done,
  output logic                     overflow
);

  localparam int NP = DEPTH / 2;
  localparam int AW = $clog2(NP) + 1;
  localparam int IW = AW - 1;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int PW = (BL == BL8) ? 2 : 1;
  localparam logic [PW-1:0] LAST = PW'(BL / 2 - 1);

  logic dstrobe;
  logic fstrobe;
  logic armed;
  logic arm_tog;
  logic done_tog;
  logic wovf;
  logic full;

  logic [DQ_W-1:0]   hold;
  logic [2*DQ_W-1:0] mem [NP];
  logic [2*DQ_W-1:0] rword;

  logic [AW-1:0] wbin;
  logic [AW-1:0] wnext;
  logic [AW-1:0] wgray;
  logic [AW-1:0] wgray_s;
  logic [AW-1:0] wbin_s;
  logic [AW-1:0] rbin;
  logic [AW-1:0] rnext;
  logic [AW-1:0] rgray;
  logic [AW-1:0] rgray_s;
  logic [AW-1:0] rbin_s;
  logic [AW-1:0] diff;
  logic [PW-1:0] pcnt;

  logic rsel;
  logic pop;
  logic tog_s;
  logic tog_d;

  logic dly [DLY_STAGES+1];

  assign dly[0] = strobe;

  for (genvar i = 0; i < DLY_STAGES; i++) begin : g_dly
`ifdef DDR2_CAPTURE_DLY_CHAIN_EN
    (* dont_touch = "true" *)
    CLKBUF2 DELAY (
      .A (dly[i]),
      .Y (dly[i+1])
    );
`else
    assign dly[i+1] = dly[i];
`endif
  end

  assign dstrobe = dly[DLY_STAGES];

  // Armed spans listen rise to the last falling edge of the burst.
  assign armed   = arm_tog ^ done_tog;
  assign fstrobe = dstrobe & (listen | armed);

  always_ff @(posedge listen or posedge reset) begin
    if (reset) begin
      arm_tog <= 1'b0;
    end else if (!armed) begin
      arm_tog <= ~arm_tog;
    end
  end

  always_ff @(posedge fstrobe or posedge reset) begin
    if (reset) begin
      hold <= '0;
    end else begin
      hold <= din;
    end
  end

  assign rbin_s = AW'(gray2bin(GW'(rgray_s)));
  assign full   = (wbin - rbin_s) == AW'(NP);
  assign wnext  = wbin + 1'b1;

  always_ff @(negedge fstrobe or posedge reset) begin
    if (reset) begin
      wbin     <= '0;
      wgray    <= '0;
      pcnt     <= '0;
      done_tog <= 1'b0;
      wovf     <= 1'b0;
    end else begin
      if (full) begin
        wovf <= 1'b1;
      end else begin
        wbin  <= wnext;
        wgray <= AW'(bin2gray(GW'(wnext)));
      end
      if (pcnt == LAST) begin
        pcnt     <= '0;
        done_tog <= ~done_tog;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(negedge fstrobe) begin
    if (!full) begin
      mem[wbin[IW-1:0]] <= {din, hold};
    end
  end

  // Read pointer is only observed on DQS edges, so full can be stale-high.
  ddr2_gray_sync #(.W(AW)) u_rsync (
    .clk   (dstrobe),
    .reset (reset),
    .d     (rgray),
    .q     (rgray_s)
  );

  ddr2_gray_sync #(.W(AW)) u_wsync (
    .clk   (clk),
    .reset (reset),
    .d     (wgray),
    .q     (wgray_s)
  );

  ddr2_gray_sync #(.W(1)) u_tsync (
    .clk   (clk),
    .reset (reset),
    .d     (done_tog),
    .q     (tog_s)
  );

  ddr2_gray_sync #(.W(1)) u_osync (
    .clk   (clk),
    .reset (reset),
    .d     (wovf),
    .q     (overflow)
  );

  assign wbin_s   = AW'(gray2bin(GW'(wgray_s)));
  assign diff     = wbin_s - rbin;
  assign level    = {diff, 1'b0} - LW'(rsel);
  assign rd_valid = level != '0;
  assign pop      = rd_en & rd_valid;
  assign rnext    = rbin + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rbin  <= '0;
      rgray <= '0;
      rsel  <= 1'b0;
      tog_d <= 1'b0;
    end else begin
      tog_d <= tog_s;
      if (pop) begin
        rsel <= ~rsel;
        if (rsel) begin
          rbin  <= rnext;
          rgray <= AW'(bin2gray(GW'(rnext)));
        end
      end
    end
  end

  assign burst_done = tog_s ^ tog_d;
  assign rword      = mem[rbin[IW-1:0]];

  always_comb begin
    dout = '0;
    if (rd_valid) begin
      dout = rsel ? rword[2*DQ_W-1:DQ_W] : rword[DQ_W-1:0];
    end
  end

endmodule

// File: tb/tb_ddr2_capture_fifo.sv
// Directed scoreboard bench for ddr2_capture_fifo, BL=4 and BL=8 instances.
// Shared DQ/DQS; each instance armed by its own listen line.
module tb_ddr2_capture_fifo;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic strobe = 1'b0;
  logic [15:0] din = '0;
  logic listen4 = 1'b0;
  logic listen8 = 1'b0;
  logic rd_en4 = 1'b0;
  logic rd_en8 = 1'b0;

  logic [15:0] dout4, dout8;
  logic        rd_valid4, rd_valid8;
  logic [4:0]  level4, level8;
  logic        burst_done4, burst_done8;
  logic        overflow4, overflow8;

  int ncomp = 0;
  int nfail = 0;
  int bd4 = 0;
  int bd8 = 0;

  logic [15:0] exp4 [$];
  logic [15:0] exp8 [$];

  ddr2_capture_fifo #(
    .DQ_W(16), .BL(4), .DEPTH(16), .DLY_STAGES(4)
  ) u4 (
    .clk        (clk),
    .reset      (reset),
    .listen     (listen4),
    .strobe     (strobe),
    .din        (din),
    .rd_en      (rd_en4),
    .dout       (dout4),
    .rd_valid   (rd_valid4),
    .level      (level4),
    .burst_done (burst_done4),
    .overflow   (overflow4)
  );

  ddr2_capture_fifo #(
    .DQ_W(16), .BL(8), .DEPTH(16), .DLY_STAGES(4)
  ) u8 (
    .clk        (clk),
    .reset      (reset),
    .listen     (listen8),
    .strobe     (strobe),
    .din        (din),
    .rd_en      (rd_en8),
    .dout       (dout8),
    .rd_valid   (rd_valid8),
    .level      (level8),
    .burst_done (burst_done8),
    .overflow   (overflow8)
  );

  always #5 clk = ~clk;

  // Pulses are one cycle wide, so each is seen at exactly one posedge.
  always @(posedge clk) begin
    if (burst_done4) bd4++;
    if (burst_done8) bd8++;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(
    input bit          b8,
    input int          n,
    input logic [15:0] base,
    input bit          arm,
    input bit          keep
  );
    if (arm) begin
      if (b8) listen8 = 1'b1;
      else    listen4 = 1'b1;
      #2;
      listen4 = 1'b0;
      listen8 = 1'b0;
      #2;
    end
    for (int i = 0; i < n; i += 2) begin
      din = base + 16'(i);
      #1 strobe = 1'b1;
      #2 din = base + 16'(i + 1);
      #1 strobe = 1'b0;
      #2;
      if (keep) begin
        if (b8) begin
          exp8.push_back(base + 16'(i));
          exp8.push_back(base + 16'(i + 1));
        end else begin
          exp4.push_back(base + 16'(i));
          exp4.push_back(base + 16'(i + 1));
        end
      end
    end
  endtask

  // Called at a negedge; pops one word after checking it.
  task automatic pop(input bit b8, input string tag);
    logic [15:0] e;
    int t;
    t = 0;
    while (!(b8 ? rd_valid8 : rd_valid4) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (b8) e = exp8.pop_front();
    else    e = exp4.pop_front();
    check({tag, "_valid"}, b8 ? rd_valid8 : rd_valid4, 1);
    check(tag, b8 ? dout8 : dout4, e);
    if (b8) rd_en8 = 1'b1;
    else    rd_en4 = 1'b1;
    @(negedge clk);
    rd_en4 = 1'b0;
    rd_en8 = 1'b0;
  endtask

  task automatic settle();
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int t;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_dout4", dout4, 0);
    check("rst_valid4", rd_valid4, 0);
    check("rst_level4", level4, 0);
    check("rst_done4", burst_done4, 0);
    check("rst_ovf4", overflow4, 0);
    check("rst_level8", level8, 0);
    check("rst_ovf8", overflow8, 0);
    reset = 1'b0;
    settle();

    // DQS activity without listen must be ignored.
    send(1'b0, 8, 16'hFFFF, 1'b0, 1'b0);
    settle();
    check("nolisten_level4", level4, 0);
    check("nolisten_level8", level8, 0);
    check("nolisten_done4", bd4, 0);
    check("nolisten_done8", bd8, 0);

    // Single BL4 burst.
    send(1'b0, 4, 16'hA001, 1'b1, 1'b1);
    settle();
    check("a_level", level4, 4);
    check("a_done", bd4, 1);
    check("a_ovf", overflow4, 0);
    for (int k = 0; k < 4; k++) pop(1'b0, "a_pop");
    check("a_valid_empty", rd_valid4, 0);
    check("a_dout_empty", dout4, 0);
    check("a_level_empty", level4, 0);

    // Two back-to-back BL8 bursts fill DEPTH=16, then one is dropped.
    send(1'b1, 8, 16'hB001, 1'b1, 1'b1);
    send(1'b1, 8, 16'hC001, 1'b1, 1'b1);
    settle();
    check("bc_level", level8, 16);
    check("bc_done", bd8, 2);
    check("bc_ovf", overflow8, 0);
    send(1'b1, 8, 16'hD001, 1'b1, 1'b0);
    settle();
    check("d_ovf", overflow8, 1);
    check("d_level", level8, 16);
    check("d_done", bd8, 3);
    for (int k = 0; k < 16; k++) pop(1'b1, "bc_pop");
    check("bc_valid_empty", rd_valid8, 0);
    check("bc_dout_empty", dout8, 0);
    check("ovf_sticky", overflow8, 1);
    check("ovf4_clear", overflow4, 0);

    // Reset after three beats of a BL4 burst.
    listen4 = 1'b1;
    #2 listen4 = 1'b0;
    #2 din = 16'h9991;
    #1 strobe = 1'b1;
    #2 din = 16'h9992;
    #1 strobe = 1'b0;
    #2 din = 16'h9993;
    #1 strobe = 1'b1;
    #2 reset = 1'b1;
    #2 strobe = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_dout4", dout4, 0);
    check("mid_valid4", rd_valid4, 0);
    check("mid_level4", level4, 0);
    check("mid_done4", burst_done4, 0);
    check("mid_ovf8", overflow8, 0);
    check("mid_level8", level8, 0);
    send(1'b0, 4, 16'hE001, 1'b1, 1'b1);
    settle();
    check("e_level", level4, 4);
    for (int k = 0; k < 4; k++) pop(1'b0, "e_pop");
    check("e_valid_empty", rd_valid4, 0);

    // rd_en held through empty, then a burst arrives.
    rd_en4 = 1'b1;
    repeat (4) @(negedge clk);
    check("f_pre_valid", rd_valid4, 0);
    check("f_pre_level", level4, 0);
    send(1'b0, 4, 16'hF001, 1'b1, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (!rd_valid4 && t < 20) begin
        @(negedge clk);
        t++;
      end
      check("f_valid", rd_valid4, 1);
      check("f_pop", dout4, exp4.pop_front());
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("f_post_valid", rd_valid4, 0);
    check("f_post_level", level4, 0);
    check("f_post_dout", dout4, 0);
    rd_en4 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncomp, nfail);
    $finish;
  end

endmodule
